// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and main memory.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int RISC_data = 32,
    parameter int main_data = 128
);
    logic                 req0_RE;
    logic                 req0_WE;
    logic [7:0]           req0_A;
    logic [RISC_data-1:0] req0_WD;
    logic                 req1_RE;
    logic                 req1_WE;
    logic [7:0]           req1_A;
    logic [RISC_data-1:0] req1_WD;
    logic                 mem_RE;
    logic                 mem_WE;
    logic [7:0]           mem_A;
    logic [RISC_data-1:0] mem_WD;
    logic [main_data-1:0] mem_RD;
    logic [main_data-1:0] RD;
    logic                 done0;
    logic                 done1;
    logic                 busy;
    logic [1:0]           grant;

    modport slave (
        input  req0_RE, req0_WE, req0_A, req0_WD,
        input  req1_RE, req1_WE, req1_A, req1_WD,
        input  mem_RD,
        output mem_RE, mem_WE, mem_A, mem_WD,
        output RD, done0, done1, busy, grant
    );

    modport master (
        output req0_RE, req0_WE, req0_A, req0_WD,
        output req1_RE, req1_WE, req1_A, req1_WD,
        output mem_RD,
        input  mem_RE, mem_WE, mem_A, mem_WD,
        input  RD, done0, done1, busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency main memory.
// One access at a time: IDLE picks a winner, ACCESS strobes memory, DONE pulses completion.
module mem_arbiter #(
    parameter int RISC_data = 32,
    parameter int main_data = 128,
    parameter int MEM_LAT   = 4
) (
    input  logic          clk,
    input  logic          RST,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state
);
    // Valid/ready semantics: a port request (RE|WE) is taken only in IDLE; the
    // requester holds it stable until its done pulse, which is the only ack.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 win_q, win_d;
    logic                 wr_q, wr_d;
    logic [7:0]           a_q, a_d;
    logic [RISC_data-1:0] wd_q, wd_d;
    logic [main_data-1:0] rd_q, rd_d;
    logic                 r0, r1, pick;

    assign r0 = bus.req0_RE | bus.req0_WE;
    assign r1 = bus.req1_RE | bus.req1_WE;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            a_q     <= 8'd0;
            wd_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        a_d     = a_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        // Under contention the port that did not win last time goes first.
        pick    = (r0 && r1) ? ~last_q : r1;
        case (state_q)
            IDLE: begin
                if (r0 || r1) begin
                    win_d   = pick;
                    last_d  = pick;
                    wr_d    = pick ? bus.req1_WE : bus.req0_WE;
                    a_d     = pick ? bus.req1_A  : bus.req0_A;
                    wd_d    = pick ? bus.req1_WD : bus.req0_WD;
                    cnt_d   = 4'(MEM_LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rd_d = bus.mem_RD;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_RE = (state_q == ACCESS) && !wr_q;
    assign bus.mem_WE = (state_q == ACCESS) &&  wr_q;
    assign bus.mem_A  = a_q;
    assign bus.mem_WD = wd_q;
    assign bus.RD     = rd_q;
    assign bus.done0  = (state_q == DONE) && !win_q;
    assign bus.done1  = (state_q == DONE) &&  win_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.grant  = (state_q == IDLE) ? 2'b00 : (win_q ? 2'b10 : 2'b01);
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: accesses are queued in expected service order
// and checked per strobe cycle and at every done pulse.
module tb_mem_arbiter;
    localparam int RW  = 32;
    localparam int MW  = 128;
    localparam int LAT = 4;
    localparam int EW  = 1 + 1 + 8 + RW + MW;

    logic       clk = 1'b0;
    logic       RST;
    logic [1:0] dbg_state;
    logic [3:0] strobe_cnt;

    always #5 clk = ~clk;

    mem_arbiter_if #(.RISC_data(RW), .main_data(MW)) bus ();

    mem_arbiter #(.RISC_data(RW), .main_data(MW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .RST       (RST),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Memory model: the block changes every strobe cycle, so only a capture at
    // the last strobe edge yields the expected word.
    function automatic logic [MW-1:0] mem_word(input logic [7:0] a, input logic [3:0] c);
        return {24'hC0DE00, a, 28'h1234000, c, ~{24'h0, a}, 32'h5A5A5A5A ^ {4{a}}};
    endfunction

    always @(posedge clk or negedge RST) begin
        if (!RST) strobe_cnt <= 4'd0;
        else if (bus.mem_RE || bus.mem_WE) strobe_cnt <= strobe_cnt + 4'd1;
        else strobe_cnt <= 4'd0;
    end

    assign bus.mem_RD = bus.mem_RE ? mem_word(bus.mem_A, strobe_cnt) : {4{32'hBAD0BAD0}};

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [MW-1:0] cur_rd = '0;
    int rem0 = 0;
    int rem1 = 0;
    bit gap_on = 1'b0;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every strobe cycle is matched against the head of the queue.
    int cyc = 0;
    int busy_cnt = 0;
    int strb_cnt = 0;
    int prev_done = -1;
    logic [EW-1:0] mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!gap_on) prev_done = -1;
        if (!RST) begin
            busy_cnt = 0;
            strb_cnt = 0;
        end else begin
            busy_cnt = bus.busy ? busy_cnt + 1 : 0;
            chk("done_excl", MW'(bus.done0 & bus.done1), '0);
            if (bus.mem_RE || bus.mem_WE) begin
                strb_cnt++;
                if (exp_q.size() == 0) begin
                    chk("strobe_unexp", MW'({bus.mem_RE, bus.mem_WE}), '0);
                end else begin
                    mon_e = exp_q[0];
                    chk("mem_A", MW'(bus.mem_A), MW'(mon_e[EW-3 -: 8]));
                    chk("mem_WE", MW'(bus.mem_WE), MW'(mon_e[EW-2]));
                    chk("mem_RE", MW'(bus.mem_RE), MW'(!mon_e[EW-2]));
                    chk("grant_acc", MW'(bus.grant), mon_e[EW-1] ? MW'(2'b10) : MW'(2'b01));
                    if (mon_e[EW-2]) chk("mem_WD", MW'(bus.mem_WD), MW'(mon_e[MW+RW-1 -: RW]));
                end
            end
            if (bus.done0 || bus.done1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexp", MW'({bus.done1, bus.done0}), '0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_port", MW'({bus.done1, bus.done0}), mon_e[EW-1] ? MW'(2'b10) : MW'(2'b01));
                    chk("grant_done", MW'(bus.grant), mon_e[EW-1] ? MW'(2'b10) : MW'(2'b01));
                    chk("RD", bus.RD, mon_e[MW-1:0]);
                    chk("strobe_len", MW'(strb_cnt), MW'(LAT));
                    chk("done_lat", MW'(busy_cnt), MW'(LAT + 1));
                    chk("strobes_off", MW'({bus.mem_RE, bus.mem_WE}), '0);
                    if (gap_on && prev_done >= 0) chk("done_gap", MW'(cyc - prev_done), MW'(LAT + 2));
                    prev_done = cyc;
                end
                strb_cnt = 0;
            end
        end
    end

    task automatic set0(input logic re, input logic we, input logic [7:0] a, input logic [RW-1:0] wd);
        bus.req0_RE = re; bus.req0_WE = we; bus.req0_A = a; bus.req0_WD = wd;
    endtask

    task automatic set1(input logic re, input logic we, input logic [7:0] a, input logic [RW-1:0] wd);
        bus.req1_RE = re; bus.req1_WE = we; bus.req1_A = a; bus.req1_WD = wd;
    endtask

    task automatic expect_acc(input logic port, input logic wr, input logic [7:0] a, input logic [RW-1:0] wd);
        if (!wr) cur_rd = mem_word(a, 4'(LAT - 1));
        exp_q.push_back({port, wr, a, wd, cur_rd});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  MW'(bus.busy), '0);
        chk({tag, "_grant"}, MW'(bus.grant), '0);
        chk({tag, "_strb"},  MW'({bus.mem_RE, bus.mem_WE}), '0);
        chk({tag, "_done"},  MW'({bus.done0, bus.done1}), '0);
        chk({tag, "_RD"},    bus.RD, '0);
        chk({tag, "_memA"},  MW'(bus.mem_A), '0);
        chk({tag, "_memWD"}, MW'(bus.mem_WD), '0);
        chk({tag, "_state"}, MW'(dbg_state), '0);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b0;
        set0(0, 0, 8'h00, '0);
        set1(0, 0, 8'h00, '0);
        exp_q.delete();
        cur_rd = '0;
        rem0 = 0;
        rem1 = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state(tag);
        RST = 1'b1;
    endtask

    // Requesters drop their request in the done cycle once their last access completes.
    task automatic run(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.done0 && rem0 > 0) begin
                rem0--;
                if (rem0 == 0) set0(0, 0, 8'h00, '0);
            end
            if (bus.done1 && rem1 > 0) begin
                rem1--;
                if (rem1 == 0) set1(0, 0, 8'h00, '0);
            end
        end
        chk("timeout", MW'(exp_q.size()), '0);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!bus.busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("busy_rise", MW'(bus.busy), MW'(1));
    endtask

    initial begin
        logic [7:0]    a0, a1;
        logic [RW-1:0] wd1;
        RST = 1'b1;
        set0(0, 0, 8'h00, '0);
        set1(0, 0, 8'h00, '0);
        #3;
        do_reset("por");

        // Single read on port 0.
        @(negedge clk); #1;
        expect_acc(0, 0, 8'h25, '0);
        set0(1, 0, 8'h25, '0);
        rem0 = 1;
        run(40);

        // Contention straight after reset: port 0 first, then port 1's write.
        do_reset("rst2");
        @(negedge clk); #1;
        expect_acc(0, 0, 8'h31, '0);
        expect_acc(1, 1, 8'h77, 32'h11223344);
        set0(1, 0, 8'h31, '0);
        set1(0, 1, 8'h77, 32'h11223344);
        rem0 = 1;
        rem1 = 1;
        gap_on = 1'b1;
        run(80);
        gap_on = 1'b0;

        // Both ports re-request continuously: grants must alternate.
        a0  = 8'($urandom_range(0, 255));
        a1  = 8'($urandom_range(0, 255));
        wd1 = $urandom;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            expect_acc(0, 0, a0, '0);
            expect_acc(1, 1, a1, wd1);
        end
        set0(1, 0, a0, '0);
        set1(0, 1, a1, wd1);
        rem0 = 3;
        rem1 = 3;
        gap_on = 1'b1;
        run(200);
        gap_on = 1'b0;

        // RE and WE together on port 1 is a write; RD must keep the last read block.
        @(negedge clk); #1;
        expect_acc(1, 1, 8'h9A, 32'hDEADBEEF);
        set1(1, 1, 8'h9A, 32'hDEADBEEF);
        rem1 = 1;
        run(40);

        // Port 0 toggles wildly while port 1 owns the memory.
        @(negedge clk); #1;
        expect_acc(1, 0, 8'h66, '0);
        set1(1, 0, 8'h66, '0);
        rem1 = 1;
        wait_busy(10);
        for (int i = 0; i < LAT - 1; i++) begin
            set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), $urandom);
            @(negedge clk); #1;
        end
        set0(0, 0, 8'h00, '0);
        run(40);

        // Reset asserted in the second ACCESS cycle: no done, nothing resumed.
        @(negedge clk); #1;
        expect_acc(1, 0, 8'h12, '0);
        set1(1, 0, 8'h12, '0);
        wait_busy(10);
        @(negedge clk); #1;
        chk("mid_strobe", MW'(bus.mem_RE), MW'(1));
        #2;
        RST = 1'b0;
        #1;
        check_reset_state("mid");
        do_reset("mid2");
        repeat (LAT + 3) @(negedge clk);
        #1;
        chk("no_resume", MW'(bus.busy), '0);
        expect_acc(1, 0, 8'h13, '0);
        set1(1, 0, 8'h13, '0);
        rem1 = 1;
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RISC_data, default 32, write-through word width.
REQ-002 Parameter main_data, default 128, memory block width.
REQ-003 Parameter MEM_LAT, default 4, memory strobe cycles per access; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 req0_RE, req0_WE  input  1 each  port 0 (instruction cache) read / write request.
REQ-007 req0_A  input  8  port 0 address; req0_WD  input  RISC_data  port 0 write word.
REQ-008 req1_RE, req1_WE  input  1 each  port 1 (data cache) read / write request.
REQ-009 req1_A  input  8  port 1 address; req1_WD  input  RISC_data  port 1 write word.
REQ-010 mem_RE, mem_WE  output  1 each  main memory strobes.
REQ-011 mem_A  output  8; mem_WD  output  RISC_data; mem_RD  input  main_data.
REQ-012 RD  output  main_data  registered read block; valid only with a done pulse.
REQ-013 done0, done1  output  1 each  per-port completion pulses.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 grant  output  2  one-hot owner of the current access; 00 in IDLE.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE: on an edge with any request active, latch winner, op, A, WD; load counter with MEM_LAT-1; go to ACCESS; otherwise stay.
REQ-018 Port request = RE | WE; if RE and WE are both high on a port, the access is a write.
REQ-019 Arbitration is round-robin: with both ports requesting, grant the port not granted last; with one requesting, grant it.
REQ-020 last_grant register updates only on grant; resets to port 1, so port 0 wins the first contention.
REQ-021 ACCESS: drive mem_A/mem_WD from latches; mem_RE=1 for reads, mem_WE=1 for writes; never both.
REQ-022 ACCESS: counter decrements each edge; at the edge where counter is 0, capture mem_RD into RD on reads, go to DONE.
REQ-023 Strobes are high for exactly MEM_LAT consecutive cycles per access.
REQ-024 DONE: pulse done of the granted port for exactly one cycle; strobes low; go to IDLE next edge.
REQ-025 Latency: request sampled at edge k -> strobes high in cycles k+1..k+MEM_LAT -> done high in cycle k+MEM_LAT+1.
REQ-026 RD holds its value until the next read capture; writes leave RD unchanged.
REQ-027 Requester inputs and the losing port are ignored outside IDLE; no queuing.
REQ-028 Requesters hold request, address, and data stable until their done and deassert the cycle after done; a request still high in IDLE is a new access.
REQ-029 Back-to-back: minimum spacing between done pulses is MEM_LAT+2 cycles; IDLE lasts at least one cycle between accesses.
REQ-030 done0 and done1 are never high together; neither is high outside DONE.
REQ-031 Illegal state encoding returns to IDLE on the next edge.

Reset
REQ-032 RST low, asynchronously at any time including mid-access: state=IDLE; counter=0; last_grant=port 1; mem_RE=mem_WE=0; done0=done1=0; busy=0; grant=00; RD=0; mem_A=0; mem_WD=0.
REQ-033 An access interrupted by reset produces no done pulse and is not resumed.

Verification (MEM_LAT=4)
REQ-034 Single read: req0_RE=1, A=8'h25 sampled edge 0 -> mem_RE high cycles 1-4, mem_A=8'h25, RD=mem_RD, done0 in cycle 5, grant=01 cycles 1-5.
REQ-035 Contention after reset: req0_RE and req1_WE both high -> port 0 served first; port 1 held -> port 1 write granted after port 0's done, with one IDLE cycle between.
REQ-036 Round-robin fairness: both ports continuously re-request for 6 accesses -> grants alternate 0,1,0,1,0,1; done spacing 6 cycles.
REQ-037 RE+WE on port 1, WD=32'hDEADBEEF -> mem_WE=1 for 4 cycles, mem_RE=0, mem_WD=32'hDEADBEEF, RD unchanged, done1 once.
REQ-038 Reset mid-access: RST low in cycle 2 of ACCESS -> strobes drop immediately, busy=0, no done; after release, a new req1_RE completes normally.
REQ-039 Port 0 request change during port 1 access -> no effect on mem_A, strobes, or done timing.
